// File: rtl/isa_pkg.sv
`default_nettype none
// ============================================================================
// isa_pkg : shared window constants, FSM states and select-bit indices
// Revision: 1.0
// ============================================================================
package isa_pkg;

    localparam logic [15:0] JOY_BASE_DEF = 16'h0201;
    localparam logic [15:0] SB_BASE_DEF  = 16'h0220;
    localparam logic [15:0] MPU_BASE_DEF = 16'h0330;
    localparam logic [15:0] FM_BASE_DEF  = 16'h0388;

    localparam logic [15:0] JOY_SIZE = 16'd1;
    localparam logic [15:0] SB_SIZE  = 16'd16;
    localparam logic [15:0] MPU_SIZE = 16'd2;
    localparam logic [15:0] FM_SIZE  = 16'd4;

    localparam int SEL_JOY = 0;
    localparam int SEL_SB  = 1;
    localparam int SEL_FM  = 2;
    localparam int SEL_MPU = 3;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ADDR    = 3'd1,
        ST_READ    = 3'd2,
        ST_WRITE   = 3'd3,
        ST_RECOVER = 3'd4
    } state_t;

    // Unsigned offset compare: addresses below base wrap to large offsets.
    function automatic logic in_window(input logic [15:0] a,
                                       input logic [15:0] base,
                                       input logic [15:0] size);
        logic [15:0] off;
        off = a - base;
        return off < size;
    endfunction

endpackage
`default_nettype wire

// File: rtl/isa_sync.sv
`default_nettype none
// ============================================================================
// isa_sync : N-stage single-bit synchroniser with configurable reset value
// Revision: 1.0
// ============================================================================
module isa_sync #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] r_ff;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ff <= {STAGES{RESET_VAL}};
        end else begin
            r_ff <= {r_ff[STAGES-2:0], d};
        end
    end

    assign q = r_ff[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/isa_io_decode.sv
`default_nettype none
// ============================================================================
// isa_io_decode : ISA I/O front-end - strobe sync/filter, window decode,
//                 single-cycle read/write strobes with byte-lane steering
// Revision: 1.0
// ============================================================================
module isa_io_decode
    import isa_pkg::*;
#(
    parameter logic [15:0] JOY_BASE    = JOY_BASE_DEF,
    parameter logic [15:0] SB_BASE     = SB_BASE_DEF,
    parameter logic [15:0] MPU_BASE    = MPU_BASE_DEF,
    parameter logic [15:0] FM_BASE     = FM_BASE_DEF,
    parameter int          SYNC_STAGES = 2,
    parameter int          MIN_LOW     = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        isa_bale,
    input  logic        isa_aen,
    input  logic        isa_ior_n,
    input  logic        isa_iow_n,
    input  logic        isa_sbhe_n,
    input  logic [15:0] isa_sa,
    input  logic [15:0] isa_sd,
    output logic [15:0] addr,
    output logic [3:0]  sel,
    output logic        rd_stb,
    output logic        rd_active,
    output logic        sd_oe,
    output logic        wr_stb,
    output logic [7:0]  wr_data
);

    localparam int             CNT_W   = $clog2(MIN_LOW + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MIN_LOW);
    localparam logic [CNT_W-1:0] CNT_HIT = CNT_W'(MIN_LOW - 1);

    logic w_bale, w_aen, w_ior_n, w_iow_n, w_sbhe_n;

    isa_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_bale
        (.clk(clk), .rst_n(rst_n), .d(isa_bale),   .q(w_bale));
    isa_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_aen
        (.clk(clk), .rst_n(rst_n), .d(isa_aen),    .q(w_aen));
    isa_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ior
        (.clk(clk), .rst_n(rst_n), .d(isa_ior_n),  .q(w_ior_n));
    isa_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_iow
        (.clk(clk), .rst_n(rst_n), .d(isa_iow_n),  .q(w_iow_n));
    isa_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_sbhe
        (.clk(clk), .rst_n(rst_n), .d(isa_sbhe_n), .q(w_sbhe_n));

    logic [15:0]      r_sa, r_sd, r_wr_sample;
    logic             r_bale_d, r_sbhe_sample_n;
    logic [CNT_W-1:0] r_ior_cnt, r_iow_cnt;
    state_t           r_state, w_state_nx;

    // Address/data buses are held stable by the ISA protocol around the
    // qualifying strobes, so a single capture stage is sufficient.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sa            <= '0;
            r_sd            <= '0;
            r_bale_d        <= 1'b0;
            r_ior_cnt       <= '0;
            r_iow_cnt       <= '0;
            r_wr_sample     <= '0;
            r_sbhe_sample_n <= 1'b1;
        end else begin
            r_sa     <= isa_sa;
            r_sd     <= isa_sd;
            r_bale_d <= w_bale;
            if (w_ior_n)                r_ior_cnt <= '0;
            else if (r_ior_cnt != CNT_MAX) r_ior_cnt <= r_ior_cnt + 1'b1;
            if (w_iow_n)                r_iow_cnt <= '0;
            else if (r_iow_cnt != CNT_MAX) r_iow_cnt <= r_iow_cnt + 1'b1;
            if (!w_iow_n) begin
                r_wr_sample     <= r_sd;
                r_sbhe_sample_n <= w_sbhe_n;
            end
        end
    end

    // Hit fires on the clock where the counter reaches MIN_LOW.
    logic w_bale_fall, w_ior_hit, w_iow_hit;
    assign w_bale_fall = r_bale_d & ~w_bale;
    assign w_ior_hit   = ~w_ior_n & (r_ior_cnt >= CNT_HIT);
    assign w_iow_hit   = ~w_iow_n & (r_iow_cnt >= CNT_HIT);

    logic [3:0] w_win_sel;
    always_comb begin
        w_win_sel = '0;
        if (!w_aen) begin
            if (in_window(r_sa, JOY_BASE, JOY_SIZE))     w_win_sel[SEL_JOY] = 1'b1;
            else if (in_window(r_sa, SB_BASE, SB_SIZE))  w_win_sel[SEL_SB]  = 1'b1;
            else if (in_window(r_sa, FM_BASE, FM_SIZE))  w_win_sel[SEL_FM]  = 1'b1;
            else if (in_window(r_sa, MPU_BASE, MPU_SIZE)) w_win_sel[SEL_MPU] = 1'b1;
        end
    end

    logic [15:0] w_addr_nx;
    logic [3:0]  w_sel_nx;
    logic        w_rd_stb_nx, w_rd_active_nx, w_wr_stb_nx;
    logic [7:0]  w_wr_data_nx;

    always_comb begin
        w_state_nx     = r_state;
        w_addr_nx      = addr;
        w_sel_nx       = sel;
        w_rd_stb_nx    = 1'b0;
        w_rd_active_nx = 1'b0;
        w_wr_stb_nx    = 1'b0;
        w_wr_data_nx   = wr_data;
        case (r_state)
            ST_IDLE, ST_ADDR: begin
                if (w_bale_fall) begin
                    w_addr_nx  = r_sa;
                    w_sel_nx   = w_win_sel;
                    w_state_nx = ST_ADDR;
                end else if (r_state == ST_ADDR && sel != 4'd0 && (w_ior_hit ^ w_iow_hit)) begin
                    if (w_ior_hit) begin
                        w_state_nx     = ST_READ;
                        w_rd_stb_nx    = 1'b1;
                        w_rd_active_nx = 1'b1;
                    end else begin
                        w_state_nx = ST_WRITE;
                    end
                end
            end
            ST_READ: begin
                if (w_ior_n) w_state_nx     = ST_RECOVER;
                else         w_rd_active_nx = 1'b1;
            end
            ST_WRITE: begin
                if (w_iow_n) begin
                    w_wr_stb_nx  = 1'b1;
                    w_wr_data_nx = (!r_sbhe_sample_n && addr[0]) ? r_wr_sample[15:8]
                                                                 : r_wr_sample[7:0];
                    w_state_nx   = ST_RECOVER;
                end
            end
            ST_RECOVER: w_state_nx = ST_IDLE;
            default:    w_state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            addr      <= '0;
            sel       <= '0;
            rd_stb    <= 1'b0;
            rd_active <= 1'b0;
            sd_oe     <= 1'b0;
            wr_stb    <= 1'b0;
            wr_data   <= '0;
        end else begin
            r_state   <= w_state_nx;
            addr      <= w_addr_nx;
            sel       <= w_sel_nx;
            rd_stb    <= w_rd_stb_nx;
            rd_active <= w_rd_active_nx;
            sd_oe     <= w_rd_active_nx;
            wr_stb    <= w_wr_stb_nx;
            wr_data   <= w_wr_data_nx;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_isa_io_decode.sv
`default_nettype none
// ============================================================================
// tb_isa_io_decode : randomized ISA cycles against a transaction-level model
// Revision: 1.0
// ============================================================================
module tb_isa_io_decode;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        isa_bale = 1'b0, isa_aen = 1'b0;
    logic        isa_ior_n = 1'b1, isa_iow_n = 1'b1, isa_sbhe_n = 1'b1;
    logic [15:0] isa_sa = '0, isa_sd = '0;
    logic [15:0] addr;
    logic [3:0]  sel;
    logic        rd_stb, rd_active, sd_oe, wr_stb;
    logic [7:0]  wr_data;

    isa_io_decode dut (
        .clk(clk), .rst_n(rst_n), .isa_bale(isa_bale), .isa_aen(isa_aen),
        .isa_ior_n(isa_ior_n), .isa_iow_n(isa_iow_n), .isa_sbhe_n(isa_sbhe_n),
        .isa_sa(isa_sa), .isa_sd(isa_sd), .addr(addr), .sel(sel),
        .rd_stb(rd_stb), .rd_active(rd_active), .sd_oe(sd_oe),
        .wr_stb(wr_stb), .wr_data(wr_data)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Model state: whether a BALE has armed the decoder, and expected outputs.
    logic        armed = 1'b0;
    logic [15:0] exp_addr = '0;
    logic [3:0]  exp_sel = '0;
    logic [7:0]  exp_wr_data = '0;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    endtask

    function automatic logic [3:0] ref_sel(input logic [15:0] sa, input logic aen);
        int a;
        a = int'(sa);
        if (aen)                          return 4'b0000;
        if (a == 'h201)                   return 4'b0001;
        if (a >= 'h220 && a <= 'h22F)     return 4'b0010;
        if (a >= 'h388 && a <= 'h38B)     return 4'b0100;
        if (a >= 'h330 && a <= 'h331)     return 4'b1000;
        return 4'b0000;
    endfunction

    task automatic bale_cycle(input logic [15:0] sa, input logic aen);
        @(negedge clk);
        isa_sa = sa; isa_aen = aen; isa_bale = 1'b1;
        repeat (2) @(negedge clk);
        isa_bale = 1'b0;
        repeat (4) @(negedge clk);
        exp_addr = sa;
        exp_sel  = ref_sel(sa, aen);
        armed    = 1'b1;
        chk("bale_addr", addr, exp_addr);
        chk("bale_sel", {12'd0, sel}, {12'd0, exp_sel});
        chk("idle_sd_oe", {15'd0, sd_oe}, 16'd0);
    endtask

    // Pin low for L sampled edges; the strobe fires L+3 edges after the fall.
    task automatic do_write(input logic [15:0] sd, input logic sbhe_n, input int L);
        logic       acc;
        logic [7:0] nd;
        acc = armed && exp_sel != 4'd0 && L >= 2;
        nd  = (!sbhe_n && exp_addr[0]) ? sd[15:8] : sd[7:0];
        @(negedge clk);
        isa_sd = sd; isa_sbhe_n = sbhe_n; isa_iow_n = 1'b0;
        for (int k = 1; k <= L + 8; k++) begin
            @(posedge clk); #1;
            if (acc && k == L + 3) exp_wr_data = nd;
            chk("wr_stb", {15'd0, wr_stb}, {15'd0, (acc && k == L + 3)});
            chk("wr_data", {8'd0, wr_data}, {8'd0, exp_wr_data});
            chk("wr_sd_oe", {15'd0, sd_oe}, 16'd0);
            chk("wr_rd_stb", {15'd0, rd_stb}, 16'd0);
            if (k == L) begin @(negedge clk); isa_iow_n = 1'b1; end
        end
        if (acc) armed = 1'b0;
        chk("wr_addr_hold", addr, exp_addr);
        chk("wr_sel_hold", {12'd0, sel}, {12'd0, exp_sel});
    endtask

    // rd_stb/sd_oe rise 4 edges after the fall; sd_oe falls 3 edges after the rise.
    task automatic do_read(input int L);
        logic acc, exp_oe;
        acc = armed && exp_sel != 4'd0 && L >= 2;
        @(negedge clk);
        isa_ior_n = 1'b0;
        for (int k = 1; k <= L + 8; k++) begin
            @(posedge clk); #1;
            exp_oe = acc && k >= 4 && k <= L + 2;
            chk("rd_stb", {15'd0, rd_stb}, {15'd0, (acc && k == 4)});
            chk("rd_sd_oe", {15'd0, sd_oe}, {15'd0, exp_oe});
            chk("rd_active", {15'd0, rd_active}, {15'd0, exp_oe});
            chk("rd_wr_stb", {15'd0, wr_stb}, 16'd0);
            if (k == L) begin @(negedge clk); isa_ior_n = 1'b1; end
        end
        if (acc) armed = 1'b0;
        chk("rd_addr_hold", addr, exp_addr);
    endtask

    task automatic do_both(input int L);
        @(negedge clk);
        isa_ior_n = 1'b0; isa_iow_n = 1'b0;
        for (int k = 1; k <= L + 8; k++) begin
            @(posedge clk); #1;
            chk("both_rd_stb", {15'd0, rd_stb}, 16'd0);
            chk("both_wr_stb", {15'd0, wr_stb}, 16'd0);
            chk("both_sd_oe", {15'd0, sd_oe}, 16'd0);
            if (k == L) begin @(negedge clk); isa_ior_n = 1'b1; isa_iow_n = 1'b1; end
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_addr"}, addr, 16'd0);
        chk({tag, "_sel"}, {12'd0, sel}, 16'd0);
        chk({tag, "_rd"}, {13'd0, rd_stb, rd_active, sd_oe}, 16'd0);
        chk({tag, "_wr_stb"}, {15'd0, wr_stb}, 16'd0);
        chk({tag, "_wr_data"}, {8'd0, wr_data}, 16'd0);
    endtask

    logic [15:0] picks [14] = '{16'h0201, 16'h0200, 16'h0202, 16'h0220, 16'h022F,
                                16'h0230, 16'h021F, 16'h0330, 16'h0331, 16'h0332,
                                16'h0388, 16'h038B, 16'h038C, 16'h0300};

    initial begin
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk_all_zero("post_reset");

        // Directed scenarios
        bale_cycle(16'h022C, 1'b0);
        do_write(16'h00D1, 1'b1, 8);
        bale_cycle(16'h0389, 1'b0);
        do_write(16'h5A00, 1'b0, 6);
        bale_cycle(16'h0201, 1'b0);
        do_read(10);
        bale_cycle(16'h0220, 1'b1);
        do_write(16'h1234, 1'b1, 6);
        bale_cycle(16'h0300, 1'b0);
        do_read(6);
        bale_cycle(16'h0331, 1'b0);
        do_read(1);
        do_both(6);
        do_read(5);

        // Reset in the middle of a write cycle
        bale_cycle(16'h0221, 1'b0);
        @(negedge clk);
        isa_sd = 16'hBEEF; isa_sbhe_n = 1'b0; isa_iow_n = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_all_zero("midwr_reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        armed = 1'b0; exp_addr = '0; exp_sel = '0; exp_wr_data = '0;
        @(negedge clk);
        isa_iow_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            chk("rst_rel_wr_stb", {15'd0, wr_stb}, 16'd0);
        end
        do_write(16'h00AA, 1'b1, 5);
        bale_cycle(16'h0221, 1'b0);
        do_write(16'hC300, 1'b0, 5);

        // Randomized cycles
        for (int t = 0; t < 40; t++) begin
            logic [15:0] sa;
            logic        aen;
            int          kind, L;
            sa   = ($urandom_range(0, 5) == 0) ? 16'($urandom) : picks[$urandom_range(0, 13)];
            aen  = ($urandom_range(0, 7) == 0);
            kind = $urandom_range(0, 9);
            L    = $urandom_range(1, 8);
            if ($urandom_range(0, 7) != 0) bale_cycle(sa, aen);
            if (kind == 0)      do_both(L);
            else if (kind < 5)  do_read(L);
            else                do_write(16'($urandom), 1'($urandom), L);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
